// File: rtl/rm_event_chain.sv
// Chained event monitor: lane tokens advance one stage per event hit, with per-stage
// flush, dwell-time timeout, registered hit/done/timeout reporting.
module rm_event_chain #(
    parameter int NUM_EVENTS     = 6,
    parameter int NUM_LANES      = 6,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 alloc_valid_i,
    input  logic [LW-1:0]                        alloc_lane_i,
    output logic                                 alloc_ready_o,
    input  logic [NUM_EVENTS-1:0]                event_i,
    input  logic [NUM_EVENTS-1:0]                flush_i,
    output logic [NUM_EVENTS-1:0][NUM_LANES-1:0] hit_o,
    output logic                                 done_valid_o,
    output logic [LW-1:0]                        done_lane_o,
    output logic [NUM_EVENTS-1:0]                timeout_o,
    output logic [NUM_EVENTS-1:0][LW-1:0]        timeout_lane_o,
    output logic [NUM_EVENTS-1:0]                occ_o
);

    localparam bit            TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [TW-1:0] AGE_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] AGE_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TW-1:0] AGE_ONE  = TW'(1);

    logic [NUM_EVENTS-1:0]                r_occ;
    logic [NUM_EVENTS-1:0][LW-1:0]        r_lane;
    logic [NUM_EVENTS-1:0][TW-1:0]        r_age;
    logic [NUM_EVENTS-1:0][NUM_LANES-1:0] r_hit;
    logic                                 r_done_valid;
    logic [LW-1:0]                        r_done_lane;
    logic [NUM_EVENTS-1:0]                r_tmo;
    logic [NUM_EVENTS-1:0][LW-1:0]        r_tmo_lane;

    // w_busy[i]: stage i cannot take a token this cycle; the extra top bit is the retire side
    logic [NUM_EVENTS:0]                  w_busy;
    logic [NUM_EVENTS-1:0]                w_fire;
    logic [NUM_EVENTS-1:0]                w_load;
    logic [NUM_EVENTS-1:0]                w_tmo;
    logic [NUM_EVENTS-1:0][LW-1:0]        w_src;
    logic [NUM_EVENTS-1:0][NUM_LANES-1:0] w_hit;

    // Fire/busy resolved from the leaf back to stage 0 so a handoff frees the slot in the same cycle
    always_comb begin
        w_busy = '0;
        w_fire = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            w_fire[i] = r_occ[i] & event_i[i] & ~flush_i[i] & ~w_busy[i+1];
            w_busy[i] = flush_i[i] | (r_occ[i] & ~w_fire[i]);
        end
    end

    // Load sources, timeout detection and one-hot hit rows
    always_comb begin
        alloc_ready_o = ~w_busy[0];
        w_load        = {w_fire[NUM_EVENTS-2:0], alloc_valid_i & ~w_busy[0]};
        w_src         = '0;
        w_tmo         = '0;
        w_hit         = '0;
        w_src[0]      = alloc_lane_i;
        for (int i = 1; i < NUM_EVENTS; i++) begin
            w_src[i] = r_lane[i-1];
        end
        for (int i = 0; i < NUM_EVENTS; i++) begin
            w_tmo[i] = TMO_EN & r_occ[i] & ~w_fire[i] & ~flush_i[i] & (r_age[i] == AGE_LAST);
            for (int l = 0; l < NUM_LANES; l++) begin
                w_hit[i][l] = w_fire[i] & (r_lane[i] == LW'(l));
            end
        end
    end

    // Stage occupancy, lane and dwell-age state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_occ  <= '0;
            r_lane <= '0;
            r_age  <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) begin
                if (w_load[i]) begin
                    r_occ[i]  <= 1'b1;
                    r_lane[i] <= w_src[i];
                    r_age[i]  <= '0;
                end else if (w_fire[i] | w_tmo[i] | flush_i[i]) begin
                    r_occ[i] <= 1'b0;
                end else if (r_occ[i] & (r_age[i] != AGE_MAX)) begin
                    r_age[i] <= r_age[i] + AGE_ONE;
                end
            end
        end
    end

    // Registered reporting: hit rows, leaf retirement and timeouts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hit        <= '0;
            r_done_valid <= 1'b0;
            r_done_lane  <= '0;
            r_tmo        <= '0;
            r_tmo_lane   <= '0;
        end else begin
            r_hit        <= w_hit;
            r_done_valid <= w_fire[NUM_EVENTS-1];
            r_done_lane  <= w_fire[NUM_EVENTS-1] ? r_lane[NUM_EVENTS-1] : '0;
            r_tmo        <= w_tmo;
            for (int i = 0; i < NUM_EVENTS; i++) begin
                r_tmo_lane[i] <= w_tmo[i] ? r_lane[i] : '0;
            end
        end
    end

    assign hit_o          = r_hit;
    assign done_valid_o   = r_done_valid;
    assign done_lane_o    = r_done_lane;
    assign timeout_o      = r_tmo;
    assign timeout_lane_o = r_tmo_lane;
    assign occ_o          = r_occ;

endmodule

// File: tb/tb_rm_event_chain.sv
// Self-checking bench for rm_event_chain: directed scenarios plus randomized traffic
// compared against a token-level reference model.
module tb_rm_event_chain;

    localparam int NE  = 6;
    localparam int NL  = 6;
    localparam int TMO = 4;
    localparam int LW  = 3;

    logic                   clk_i = 1'b0;
    logic                   rst_ni;
    logic                   alloc_valid_i;
    logic [LW-1:0]          alloc_lane_i;
    logic                   alloc_ready_o;
    logic [NE-1:0]          event_i;
    logic [NE-1:0]          flush_i;
    logic [NE-1:0][NL-1:0]  hit_o;
    logic                   done_valid_o;
    logic [LW-1:0]          done_lane_o;
    logic [NE-1:0]          timeout_o;
    logic [NE-1:0][LW-1:0]  timeout_lane_o;
    logic [NE-1:0]          occ_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    rm_event_chain #(
        .NUM_EVENTS    (NE),
        .NUM_LANES     (NL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .alloc_valid_i (alloc_valid_i),
        .alloc_lane_i  (alloc_lane_i),
        .alloc_ready_o (alloc_ready_o),
        .event_i       (event_i),
        .flush_i       (flush_i),
        .hit_o         (hit_o),
        .done_valid_o  (done_valid_o),
        .done_lane_o   (done_lane_o),
        .timeout_o     (timeout_o),
        .timeout_lane_o(timeout_lane_o),
        .occ_o         (occ_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_ni        = 1'b0;
        alloc_valid_i = 1'b0;
        alloc_lane_i  = '0;
        event_i       = '0;
        flush_i       = '0;
        tick();
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b1;
        alloc_valid_i = 1'b0;
        alloc_lane_i  = '0;
        event_i       = '0;
        flush_i       = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (occ_o !== 6'b0) begin failures++; $display("FAIL reset_occ got=%b exp=%b", occ_o, 6'b0); end
        checks++; if (hit_o !== 36'b0) begin failures++; $display("FAIL reset_hit got=%h exp=0", hit_o); end
        checks++; if (done_valid_o !== 1'b0 || done_lane_o !== 3'd0) begin failures++; $display("FAIL reset_done got=%b/%0d exp=0/0", done_valid_o, done_lane_o); end
        checks++; if (timeout_o !== 6'b0 || timeout_lane_o !== 18'b0) begin failures++; $display("FAIL reset_timeout got=%b/%h exp=0/0", timeout_o, timeout_lane_o); end
        checks++; if (alloc_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", alloc_ready_o); end
        flush_i = 6'b000001;
        #1;
        checks++; if (alloc_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready_flush got=%b exp=0", alloc_ready_o); end
        flush_i = 6'b0;
        tick();
        rst_ni = 1'b1;
    endtask

    task automatic test_single_traverse();
        logic [NE-1:0][NL-1:0] exp_hit;
        logic [NE-1:0]         exp_occ;
        apply_reset();
        alloc_valid_i = 1'b1;
        alloc_lane_i  = 3'd3;
        tick();
        alloc_valid_i = 1'b0;
        checks++; if (occ_o !== 6'b000001) begin failures++; $display("FAIL trav_load got=%b exp=%b", occ_o, 6'b000001); end
        for (int k = 0; k < NE; k++) begin
            event_i = 6'(1 << k);
            tick();
            exp_hit       = '0;
            exp_hit[k][3] = 1'b1;
            exp_occ       = (k < NE - 1) ? 6'(1 << (k + 1)) : 6'b0;
            checks++; if (hit_o !== exp_hit) begin failures++; $display("FAIL trav_hit k=%0d got=%h exp=%h", k, hit_o, exp_hit); end
            checks++; if (occ_o !== exp_occ) begin failures++; $display("FAIL trav_occ k=%0d got=%b exp=%b", k, occ_o, exp_occ); end
            checks++; if (done_valid_o !== 1'(k == NE - 1)) begin failures++; $display("FAIL trav_done k=%0d got=%b exp=%b", k, done_valid_o, 1'(k == NE - 1)); end
            if (k == NE - 1) begin
                checks++; if (done_lane_o !== 3'd3) begin failures++; $display("FAIL trav_done_lane got=%0d exp=3", done_lane_o); end
            end
        end
        event_i = '0;
        tick();
        checks++; if (hit_o !== 36'b0 || done_valid_o !== 1'b0) begin failures++; $display("FAIL trav_quiet got=%h/%b exp=0/0", hit_o, done_valid_o); end
    endtask

    task automatic test_back_pressure();
        logic [NE-1:0][NL-1:0] exp_hit;
        apply_reset();
        alloc_valid_i = 1'b1;
        alloc_lane_i  = 3'd2;
        tick();
        event_i      = 6'b000001;
        alloc_lane_i = 3'd4;
        #1;
        checks++; if (alloc_ready_o !== 1'b1) begin failures++; $display("FAIL bp_handoff_ready got=%b exp=1", alloc_ready_o); end
        tick();
        exp_hit       = '0;
        exp_hit[0][2] = 1'b1;
        checks++; if (hit_o !== exp_hit) begin failures++; $display("FAIL bp_handoff_hit got=%h exp=%h", hit_o, exp_hit); end
        event_i      = 6'b000001;
        alloc_lane_i = 3'd5;
        #1;
        checks++; if (alloc_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready got=%b exp=0", alloc_ready_o); end
        tick();
        checks++; if (occ_o !== 6'b000011) begin failures++; $display("FAIL bp_occ got=%b exp=%b", occ_o, 6'b000011); end
        checks++; if (hit_o !== 36'b0) begin failures++; $display("FAIL bp_hit got=%h exp=0", hit_o); end
        alloc_valid_i = 1'b0;
        event_i       = 6'b000011;
        tick();
        exp_hit       = '0;
        exp_hit[1][2] = 1'b1;
        exp_hit[0][4] = 1'b1;
        checks++; if (hit_o !== exp_hit) begin failures++; $display("FAIL bp_drain_hit got=%h exp=%h", hit_o, exp_hit); end
        checks++; if (occ_o !== 6'b000110) begin failures++; $display("FAIL bp_drain_occ got=%b exp=%b", occ_o, 6'b000110); end
    endtask

    task automatic test_full_throughput();
        logic [LW-1:0] lanes_q[$];
        logic [LW-1:0] exp_lane;
        apply_reset();
        event_i       = '1;
        alloc_valid_i = 1'b1;
        for (int j = 0; j < 24; j++) begin
            alloc_lane_i = 3'($urandom_range(0, 5));
            lanes_q.push_back(alloc_lane_i);
            #1;
            checks++; if (alloc_ready_o !== 1'b1) begin failures++; $display("FAIL thru_ready j=%0d got=%b exp=1", j, alloc_ready_o); end
            tick();
            if (j >= NE - 1) begin
                checks++; if (occ_o !== 6'b111111) begin failures++; $display("FAIL thru_occ j=%0d got=%b exp=%b", j, occ_o, 6'b111111); end
            end
            if (j >= NE) begin
                exp_lane = lanes_q.pop_front();
                checks++; if (done_valid_o !== 1'b1 || done_lane_o !== exp_lane) begin failures++; $display("FAIL thru_done j=%0d got=%b/%0d exp=1/%0d", j, done_valid_o, done_lane_o, exp_lane); end
            end else begin
                checks++; if (done_valid_o !== 1'b0) begin failures++; $display("FAIL thru_fill j=%0d got=%b exp=0", j, done_valid_o); end
            end
        end
        alloc_valid_i = 1'b0;
    endtask

    task automatic test_timeout();
        logic [NE-1:0] exp_occ;
        logic [NE-1:0] exp_to;
        apply_reset();
        alloc_valid_i = 1'b1;
        alloc_lane_i  = 3'd1;
        tick();
        alloc_valid_i = 1'b0;
        event_i       = 6'b000001;
        tick();
        event_i = 6'b000010;
        tick();
        event_i = 6'b0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exp_occ = (c <= 3) ? 6'b000100 : 6'b0;
            exp_to  = (c == 4) ? 6'b000100 : 6'b0;
            checks++; if (occ_o !== exp_occ) begin failures++; $display("FAIL tmo_occ c=%0d got=%b exp=%b", c, occ_o, exp_occ); end
            checks++; if (timeout_o !== exp_to) begin failures++; $display("FAIL tmo_pulse c=%0d got=%b exp=%b", c, timeout_o, exp_to); end
            checks++; if (hit_o !== 36'b0) begin failures++; $display("FAIL tmo_hit c=%0d got=%h exp=0", c, hit_o); end
            if (c == 4) begin
                checks++; if (timeout_lane_o[2] !== 3'd1) begin failures++; $display("FAIL tmo_lane got=%0d exp=1", timeout_lane_o[2]); end
            end
        end
    endtask

    task automatic test_flush_collision();
        apply_reset();
        alloc_valid_i = 1'b1;
        alloc_lane_i  = 3'd5;
        tick();
        alloc_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            event_i = 6'(1 << k);
            tick();
        end
        checks++; if (occ_o !== 6'b001000) begin failures++; $display("FAIL flush_setup got=%b exp=%b", occ_o, 6'b001000); end
        event_i = 6'b001000;
        flush_i = 6'b001000;
        tick();
        checks++; if (hit_o !== 36'b0) begin failures++; $display("FAIL flush_hit got=%h exp=0", hit_o); end
        checks++; if (occ_o !== 6'b0) begin failures++; $display("FAIL flush_occ got=%b exp=0", occ_o); end
        event_i = '0;
        flush_i = '0;
        tick();
        checks++; if (occ_o !== 6'b0 || hit_o !== 36'b0 || done_valid_o !== 1'b0 || timeout_o !== 6'b0) begin failures++; $display("FAIL flush_after got=%b/%h/%b/%b exp=0", occ_o, hit_o, done_valid_o, timeout_o); end
    endtask

    task automatic test_reset_midrun();
        apply_reset();
        event_i       = '1;
        alloc_valid_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            alloc_lane_i = 3'(j);
            tick();
        end
        checks++; if (occ_o !== 6'b001111) begin failures++; $display("FAIL midrst_setup got=%b exp=%b", occ_o, 6'b001111); end
        alloc_valid_i = 1'b0;
        rst_ni        = 1'b0;
        #1;
        checks++; if (occ_o !== 6'b0 || hit_o !== 36'b0) begin failures++; $display("FAIL midrst_state got=%b/%h exp=0/0", occ_o, hit_o); end
        checks++; if (done_valid_o !== 1'b0 || done_lane_o !== 3'd0 || timeout_o !== 6'b0 || timeout_lane_o !== 18'b0) begin failures++; $display("FAIL midrst_outs got=%b/%0d/%b/%h exp=0", done_valid_o, done_lane_o, timeout_o, timeout_lane_o); end
        checks++; if (alloc_ready_o !== 1'b1) begin failures++; $display("FAIL midrst_ready got=%b exp=1", alloc_ready_o); end
        tick();
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            event_i = (c < 5) ? '1 : '0;
            tick();
            checks++; if (done_valid_o !== 1'b0 || timeout_o !== 6'b0 || occ_o !== 6'b0) begin failures++; $display("FAIL midrst_ghost c=%0d got=%b/%b/%b exp=0", c, done_valid_o, timeout_o, occ_o); end
        end
        event_i = '0;
    endtask

    task automatic test_random(input int n);
        bit                    m_occ [NE];
        int                    m_lane[NE];
        int                    m_age [NE];
        bit                    n_occ [NE];
        int                    n_lane[NE];
        int                    n_age [NE];
        bit                    adv   [NE];
        bit                    timed [NE];
        bit                    acc   [NE+1];
        bit                    incoming;
        int                    src;
        logic                  e_ready;
        logic [NE-1:0][NL-1:0] e_hit;
        logic                  e_done;
        logic [LW-1:0]         e_done_lane;
        logic [NE-1:0]         e_to;
        logic [NE-1:0][LW-1:0] e_to_lane;
        logic [NE-1:0]         e_occ;
        apply_reset();
        for (int i = 0; i < NE; i++) begin
            m_occ[i]  = 1'b0;
            m_lane[i] = 0;
            m_age[i]  = 0;
        end
        for (int t = 0; t < n; t++) begin
            alloc_valid_i = ($urandom_range(0, 9) < 7);
            alloc_lane_i  = 3'($urandom_range(0, 7));
            event_i       = 6'($urandom());
            flush_i       = '0;
            for (int i = 0; i < NE; i++) begin
                if ($urandom_range(0, 19) == 0) flush_i[i] = 1'b1;
            end
            #1;
            // A slot accepts when it is not flushed and is empty or its token leaves; retirement always accepts
            acc[NE] = 1'b1;
            for (int i = NE - 1; i >= 0; i--) begin
                adv[i] = m_occ[i] && event_i[i] && !flush_i[i] && acc[i+1];
                acc[i] = !flush_i[i] && (!m_occ[i] || adv[i]);
            end
            e_ready = acc[0];
            checks++; if (alloc_ready_o !== e_ready) begin failures++; $display("FAIL rand_ready t=%0d got=%b exp=%b", t, alloc_ready_o, e_ready); end
            e_hit       = '0;
            e_to        = '0;
            e_to_lane   = '0;
            e_done      = adv[NE-1];
            e_done_lane = adv[NE-1] ? 3'(m_lane[NE-1]) : 3'd0;
            for (int i = 0; i < NE; i++) begin
                timed[i] = m_occ[i] && !adv[i] && !flush_i[i] && (m_age[i] + 1 == TMO);
                if (adv[i] && m_lane[i] < NL) e_hit[i][m_lane[i]] = 1'b1;
                if (timed[i]) begin
                    e_to[i]      = 1'b1;
                    e_to_lane[i] = 3'(m_lane[i]);
                end
            end
            for (int i = 0; i < NE; i++) begin
                if (i == 0) begin
                    incoming = alloc_valid_i && acc[0];
                    src      = int'(alloc_lane_i);
                end else begin
                    incoming = adv[i-1];
                    src      = m_lane[i-1];
                end
                if (incoming) begin
                    n_occ[i]  = 1'b1;
                    n_lane[i] = src;
                    n_age[i]  = 0;
                end else if (m_occ[i] && !adv[i] && !flush_i[i] && !timed[i]) begin
                    n_occ[i]  = 1'b1;
                    n_lane[i] = m_lane[i];
                    n_age[i]  = (m_age[i] + 1 > TMO) ? TMO : m_age[i] + 1;
                end else begin
                    n_occ[i]  = 1'b0;
                    n_lane[i] = m_lane[i];
                    n_age[i]  = m_age[i];
                end
                e_occ[i] = n_occ[i];
            end
            tick();
            checks++; if (occ_o !== e_occ) begin failures++; $display("FAIL rand_occ t=%0d got=%b exp=%b", t, occ_o, e_occ); end
            checks++; if (hit_o !== e_hit) begin failures++; $display("FAIL rand_hit t=%0d got=%h exp=%h", t, hit_o, e_hit); end
            checks++; if (done_valid_o !== e_done) begin failures++; $display("FAIL rand_done t=%0d got=%b exp=%b", t, done_valid_o, e_done); end
            if (e_done) begin
                checks++; if (done_lane_o !== e_done_lane) begin failures++; $display("FAIL rand_done_lane t=%0d got=%0d exp=%0d", t, done_lane_o, e_done_lane); end
            end
            checks++; if (timeout_o !== e_to) begin failures++; $display("FAIL rand_timeout t=%0d got=%b exp=%b", t, timeout_o, e_to); end
            for (int i = 0; i < NE; i++) begin
                if (e_to[i]) begin
                    checks++; if (timeout_lane_o[i] !== e_to_lane[i]) begin failures++; $display("FAIL rand_timeout_lane t=%0d s=%0d got=%0d exp=%0d", t, i, timeout_lane_o[i], e_to_lane[i]); end
                end
            end
            for (int i = 0; i < NE; i++) begin
                m_occ[i]  = n_occ[i];
                m_lane[i] = n_lane[i];
                m_age[i]  = n_age[i];
            end
        end
        alloc_valid_i = 1'b0;
        event_i       = '0;
        flush_i       = '0;
    endtask

    initial begin
        test_reset();
        test_single_traverse();
        test_back_pressure();
        test_full_throughput();
        test_timeout();
        test_flush_collision();
        test_reset_midrun();
        test_random(1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
